// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and sticky fault trap.
// Optional ORI support (ORIEX/ORIWB states, extsel) is enabled by defining ORI_EN.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       regdest,
    output logic       alusrca,
    output logic       extsel,
    output logic [1:0] pcsource,
    output logic [1:0] aluop,
    output logic [1:0] alusrcb,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ORIEX  = 4'd10, S_ORIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait;
    logic          r_fault;
    logic [1:0]    r_fault_code;
    state_t        w_cur;
    logic          w_timeout;

    assign w_timeout = !mem_ready && (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            // Wait counter restarts on every transition; only a stalled memory state keeps counting.
            r_wait <= '0;
            case (r_state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (mem_ready) begin
                        case (r_state)
                            S_FETCH: r_state <= S_DECODE;
                            S_MEMRD: r_state <= S_MEMWB;
                            default: r_state <= S_FETCH;
                        endcase
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_fault      <= 1'b1;
                        r_fault_code <= 2'b10;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      r_state <= S_EXEC;
                        OP_LW, OP_SW:  r_state <= S_MEMADR;
                        OP_BEQ:        r_state <= S_BRANCH;
                        OP_J:          r_state <= S_JUMP;
`ifdef ORI_EN
                        OP_ORI:        r_state <= S_ORIEX;
`endif
                        default: begin
                            r_state      <= S_TRAP;
                            r_fault      <= 1'b1;
                            r_fault_code <= 2'b01;
                        end
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_EXEC:   r_state <= S_RWB;
`ifdef ORI_EN
                S_ORIEX:  r_state <= S_ORIWB;
                S_ORIWB:  r_state <= S_FETCH;
`endif
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // While reset is held the outputs look like FETCH, with the fetch write strobes suppressed.
    assign w_cur = reset ? S_FETCH : r_state;

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        regdest     = 1'b0;
        alusrca     = 1'b0;
        extsel      = 1'b0;
        pcsource    = 2'b00;
        aluop       = 2'b00;
        alusrcb     = 2'b00;
        instr_done  = 1'b0;
        case (w_cur)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready && !reset;
                pcwrite = mem_ready && !reset;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                regwrite   = 1'b1;
                regdest    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
            end
`ifdef ORI_EN
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                extsel  = 1'b1;
                aluop   = 2'b11;
            end
            S_ORIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state      = w_cur;
    assign fault      = r_fault && !reset;
    assign fault_code = reset ? 2'b00 : r_fault_code;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; follows ORI_EN the same way as the design.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regwrite, regdest, alusrca, extsel;
    logic [1:0] pcsource, aluop, alusrcb;
    logic [3:0] state;
    logic       instr_done, fault;
    logic [1:0] fault_code;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int held, n, trap_cnt;

    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .regdest(regdest),
        .alusrca(alusrca), .extsel(extsel), .pcsource(pcsource),
        .aluop(aluop), .alusrcb(alusrcb), .state(state),
        .instr_done(instr_done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ends the current cycle: tallies instr_done for it, then moves just past the next edge.
    task automatic tick();
        done_cnt += int'(instr_done);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_memread", memread, 1);
        chk("rst_alusrcb", alusrcb, 1);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_pcwrite", pcwrite, 0);

        // R-type, memory always ready: 0,1,6,7,0
        reset = 1'b0; #1;
        done_cnt = 0;
        chk("r_fetch_state", state, 0);
        chk("r_irwrite", irwrite, 1);
        chk("r_pcwrite", pcwrite, 1);
        tick();
        chk("r_decode_state", state, 1);
        chk("r_decode_alusrcb", alusrcb, 3);
        chk("r_decode_memread", memread, 0);
        tick();
        chk("r_exec_state", state, 6);
        chk("r_exec_alusrca", alusrca, 1);
        chk("r_exec_aluop", aluop, 2);
        tick();
        chk("r_rwb_state", state, 7);
        chk("r_rwb_regwrite", regwrite, 1);
        chk("r_rwb_regdest", regdest, 1);
        chk("r_rwb_done", instr_done, 1);
        tick();
        chk("r_back_fetch", state, 0);
        chk("r_done_pulses", done_cnt, 1);

        // lw with three wait cycles in MEMRD
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        tick();
        chk("lw_decode", state, 1);
        tick();
        chk("lw_memadr", state, 2);
        chk("lw_memadr_alusrcb", alusrcb, 2);
        chk("lw_memadr_alusrca", alusrca, 1);
        mem_ready = 1'b0;
        tick();
        chk("lw_memrd_iord", iord, 1);
        chk("lw_memrd_memread", memread, 1);
        held = 0; n = 0;
        while (state != 4'd4 && n < 20) begin
            mem_ready = (n >= 3);
            #1;
            if (state == 4'd3) held++;
            tick();
            n++;
        end
        chk("lw_memrd_held", held, 4);
        chk("lw_cycles", 3 + n + 1, 8);
        chk("lw_memwb_state", state, 4);
        chk("lw_memwb_regwrite", regwrite, 1);
        chk("lw_memwb_memtoreg", memtoreg, 1);
        chk("lw_memwb_done", instr_done, 1);
        tick();
        chk("lw_back_fetch", state, 0);

        // sw with one wait cycle in MEMWR
        opcode = 6'b101011; mem_ready = 1'b1; #1;
        tick(); tick();
        chk("sw_memadr", state, 2);
        mem_ready = 1'b0;
        tick();
        chk("sw_memwr_state", state, 5);
        chk("sw_memwr_memwrite", memwrite, 1);
        chk("sw_memwr_iord", iord, 1);
        chk("sw_wait_no_done", instr_done, 0);
        tick();
        mem_ready = 1'b1; #1;
        chk("sw_memwr_still", state, 5);
        chk("sw_done", instr_done, 1);
        tick();
        chk("sw_back_fetch", state, 0);

        // beq
        opcode = 6'b000100; #1;
        tick(); tick();
        chk("beq_state", state, 8);
        chk("beq_pcwritecond", pcwritecond, 1);
        chk("beq_pcsource", pcsource, 1);
        chk("beq_aluop", aluop, 1);
        chk("beq_done", instr_done, 1);
        tick();
        chk("beq_back_fetch", state, 0);

        // j
        opcode = 6'b000010; #1;
        tick(); tick();
        chk("j_state", state, 9);
        chk("j_pcwrite", pcwrite, 1);
        chk("j_pcsource", pcsource, 2);
        chk("j_done", instr_done, 1);
        tick();
        chk("j_back_fetch", state, 0);

        // ori
        opcode = 6'b001101; #1;
        tick(); tick();
`ifdef ORI_EN
        chk("ori_ex_state", state, 10);
        chk("ori_ex_extsel", extsel, 1);
        chk("ori_ex_aluop", aluop, 3);
        chk("ori_ex_alusrcb", alusrcb, 2);
        tick();
        chk("ori_wb_state", state, 11);
        chk("ori_wb_regwrite", regwrite, 1);
        chk("ori_wb_done", instr_done, 1);
        tick();
        chk("ori_back_fetch", state, 0);
`else
        chk("ori_trap_state", state, 15);
        chk("ori_trap_code", fault_code, 1);
        chk("ori_extsel", extsel, 0);
`endif
        do_reset();

        // illegal opcode: sticky trap
        opcode = 6'b111111; mem_ready = 1'b1; #1;
        tick(); tick();
        chk("ill_state", state, 15);
        chk("ill_fault", fault, 1);
        chk("ill_code", fault_code, 1);
        chk("ill_memread", memread, 0);
        trap_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == 4'd15) trap_cnt++;
        end
        chk("ill_trap_hold", trap_cnt, 20);
        do_reset();
        chk("ill_reset_state", state, 0);
        chk("ill_reset_fault", fault, 0);

        // fetch timeout
        opcode = 6'b000000; mem_ready = 1'b0; #1;
        n = 0;
        while (state == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_fetch_cycles", n, 15);
        chk("to_state", state, 15);
        chk("to_fault", fault, 1);
        chk("to_code", fault_code, 2);
        do_reset();

        // ready on the last allowed cycle wins over the timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("late_still_fetch", state, 0);
        mem_ready = 1'b1; #1;
        chk("late_irwrite", irwrite, 1);
        tick();
        chk("late_decode", state, 1);
        chk("late_no_fault", fault, 0);

        // reset during MEMWR
        opcode = 6'b101011; #1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("rw_memwr_state", state, 5);
        chk("rw_memwrite", memwrite, 1);
        reset = 1'b1; #1;
        tick();
        reset = 1'b0; #1;
        chk("rw_state", state, 0);
        chk("rw_memwrite_off", memwrite, 0);
        chk("rw_fault", fault, 0);
        chk("rw_code", fault_code, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
